control_unit_seq: RTL and testbench

//  Multi-cycle, handshaked RV32I control unit; successor to the combinational decoder.

---
 rtl/control_unit_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_control_unit_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// Handshaked multi-cycle RV32I control unit: accepts an instruction from fetch, decodes it in a
// registered stage and presents the control word to the datapath for HOLD_CYCLES cycles.
module control_unit_seq #(
    parameter int ALU_CTRL_W  = 4,
    parameter int HOLD_CYCLES = 1,
    parameter bit ENABLE_M    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [31:0]           Ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  Is_Imm,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            br_func3,
    output logic                  illegal,
    output logic                  done
);

    // state  | meaning
    // IDLE   | waiting for fetch; ins_ready=1 when en=1
    // DECODE | instruction fields registered, control word being computed
    // EXEC   | control word driven for HOLD_CYCLES cycles, done in the last one
    // TRAP   | one-cycle illegal pulse, controls all 0
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_TRAP} state_t;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       is_imm;
        logic [4:0] alu;
        logic [2:0] br_func3;
    } ctrl_t;

    if (ENABLE_M && ALU_CTRL_W < 5) begin : g_bad_alu_width
        $error("control_unit_seq: ENABLE_M=1 needs ALU_CTRL_W >= 5");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("control_unit_seq: HOLD_CYCLES must be >= 1");
    end

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_SUB   = 5'b00110;
    localparam logic [4:0] ALU_SLL   = 5'b00000;
    localparam logic [4:0] ALU_SLT   = 5'b00011;
    localparam logic [4:0] ALU_SLTU  = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00001;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_OR    = 5'b01000;
    localparam logic [4:0] ALU_AND   = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;
    logic [6:0]       f7_q, f7_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            dec;
    logic             dec_illegal;
    logic             in_exec;

    // funct3 -> ALU op for the shared R/I arithmetic group (funct7 variants handled by caller)
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (op_q)
            OP_R: begin
                dec.reg_write = 1'b1;
                if (f7_q == F7_ZERO)
                    dec.alu = base_alu(f3_q);
                else if (f7_q == F7_ALT && f3_q == 3'b000)
                    dec.alu = ALU_SUB;
                else if (f7_q == F7_ALT && f3_q == 3'b101)
                    dec.alu = ALU_SRA;
                else if (ENABLE_M && f7_q == F7_MUL)
                    dec.alu = {2'b10, f3_q};
                else
                    dec_illegal = 1'b1;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.is_imm    = 1'b1;
                dec.alu       = base_alu(f3_q);
                if (f3_q == 3'b001 && f7_q != F7_ZERO)
                    dec_illegal = 1'b1;
                if (f3_q == 3'b101) begin
                    if (f7_q == F7_ALT)
                        dec.alu = ALU_SRA;
                    else if (f7_q != F7_ZERO)
                        dec_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.is_imm     = 1'b1;
                dec.alu        = ALU_ADD;
                dec_illegal    = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.is_imm    = 1'b1;
                dec.alu       = ALU_ADD;
                dec_illegal   = f3_q[2] || (f3_q == 3'b011);
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.br_func3 = f3_q;
                case (f3_q[2:1])
                    2'b00:   dec.alu = ALU_SUB;
                    2'b10:   dec.alu = ALU_SLT;
                    2'b11:   dec.alu = ALU_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_JAL, OP_JALR: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.is_imm    = 1'b1;
                dec.alu       = ALU_ADD;
                dec_illegal   = (op_q == OP_JALR) && (f3_q != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.is_imm    = 1'b1;
                dec.alu       = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.is_imm    = 1'b1;
                dec.alu       = ALU_ADD;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Everything registered only advances with en=1, so a stall freezes all outputs as well.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        ctrl_d  = ctrl_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (ins_valid) begin
                        op_d    = Ins[6:0];
                        f3_d    = Ins[14:12];
                        f7_d    = Ins[31:25];
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ctrl_d = dec;
                    if (dec_illegal) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q - CNT_W'(1);
                end
                S_TRAP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        in_exec     = (state_q == S_EXEC);
        ins_ready   = rst_n & en & (state_q == S_IDLE);
        ctrl_valid  = in_exec;
        Branch      = in_exec & ctrl_q.branch;
        Jump        = in_exec & ctrl_q.jump;
        MemRead     = in_exec & ctrl_q.mem_read;
        MemWrite    = in_exec & ctrl_q.mem_write;
        MemtoReg    = in_exec & ctrl_q.mem_to_reg;
        RegWrite    = in_exec & ctrl_q.reg_write;
        Is_Imm      = in_exec & ctrl_q.is_imm;
        alu_control = in_exec ? ALU_CTRL_W'(ctrl_q.alu) : '0;
        br_func3    = in_exec ? ctrl_q.br_func3 : 3'b000;
        illegal     = (state_q == S_TRAP);
        done        = in_exec & (cnt_q == '0);
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: a HOLD=1 base-ISA instance and a HOLD=3 RV32M instance, with a
// result scoreboard per instance plus per-scenario timing checks.
module tb_control_unit_seq;

    typedef logic [16:0] exp_t;  // {illegal, valid, br, jmp, mr, mw, m2r, rw, imm, alu[4:0], bf3}

    localparam logic [6:0] F_BR  = 7'b1000000;
    localparam logic [6:0] F_JMP = 7'b0100000;
    localparam logic [6:0] F_MR  = 7'b0010000;
    localparam logic [6:0] F_MW  = 7'b0001000;
    localparam logic [6:0] F_M2R = 7'b0000100;
    localparam logic [6:0] F_RW  = 7'b0000010;
    localparam logic [6:0] F_IMM = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en1, en2, v1, v2;
    logic [31:0] ins1, ins2;
    logic        r1, cv1, br1, jp1, mr1, mw1, m2r1, rw1, imm1, il1, dn1;
    logic [3:0]  alu1;
    logic [2:0]  bf1;
    logic        r2, cv2, br2, jp2, mr2, mw2, m2r2, rw2, imm2, il2, dn2;
    logic [4:0]  alu2;
    logic [2:0]  bf2;

    exp_t q1[$];
    exp_t q2[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    control_unit_seq #(.ALU_CTRL_W(4), .HOLD_CYCLES(1), .ENABLE_M(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .Ins(ins1), .ins_valid(v1), .ins_ready(r1),
        .ctrl_valid(cv1), .Branch(br1), .Jump(jp1), .MemRead(mr1), .MemWrite(mw1),
        .MemtoReg(m2r1), .RegWrite(rw1), .Is_Imm(imm1), .alu_control(alu1),
        .br_func3(bf1), .illegal(il1), .done(dn1));

    control_unit_seq #(.ALU_CTRL_W(5), .HOLD_CYCLES(3), .ENABLE_M(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .Ins(ins2), .ins_valid(v2), .ins_ready(r2),
        .ctrl_valid(cv2), .Branch(br2), .Jump(jp2), .MemRead(mr2), .MemWrite(mw2),
        .MemtoReg(m2r2), .RegWrite(rw2), .Is_Imm(imm2), .alu_control(alu2),
        .br_func3(bf2), .illegal(il2), .done(dn2));

    always @(posedge clk) cyc++;

    function automatic exp_t ev(input logic il, input logic [6:0] fl, input logic [4:0] alu,
                                input logic [2:0] bf);
        return {il, ~il, fl, alu, bf};
    endfunction

    // Scoreboards: one result per instruction, taken on the first cycle of done or illegal.
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        exp_t obs, e;
        obs = {il1, cv1, br1, jp1, mr1, mw1, m2r1, rw1, imm1, 1'b0, alu1, bf1};
        if ((dn1 | il1) && !prev1) begin
            tot_cnt++;
            if (q1.size() == 0) begin
                $display("FAIL sb1_unexpected obs=%h", obs);
            end else begin
                e = q1.pop_front();
                if (obs !== e) $display("FAIL sb1_result obs=%h exp=%h", obs, e);
                else pass_cnt++;
            end
        end
        prev1 = dn1 | il1;
    end

    logic prev2 = 1'b0;
    always @(negedge clk) begin
        exp_t obs, e;
        obs = {il2, cv2, br2, jp2, mr2, mw2, m2r2, rw2, imm2, alu2, bf2};
        if ((dn2 | il2) && !prev2) begin
            tot_cnt++;
            if (q2.size() == 0) begin
                $display("FAIL sb2_unexpected obs=%h", obs);
            end else begin
                e = q2.pop_front();
                if (obs !== e) $display("FAIL sb2_result obs=%h exp=%h", obs, e);
                else pass_cnt++;
            end
        end
        prev2 = dn2 | il2;
    end

    // Offers one instruction; returns #1 after the accepting edge with acc_cyc set.
    task automatic issue(input int d, input logic [31:0] ins, input exp_t e);
        int n = 0;
        @(negedge clk);
        if (d == 1) begin ins1 = ins; v1 = 1'b1; end
        else        begin ins2 = ins; v2 = 1'b1; end
        while (((d == 1) ? !r1 : !r2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        tot_cnt++;
        if ((d == 1) ? r1 : r2) begin
            pass_cnt++;
            if (d == 1) q1.push_back(e);
            else        q2.push_back(e);
        end else begin
            $display("FAIL accept_timeout dut%0d ins=%h", d, ins);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en1 = 1'b1; en2 = 1'b1; v1 = 1'b0; v2 = 1'b0; ins1 = '0; ins2 = '0;
        #12;
        tot_cnt++;
        if ({r1, cv1, br1, jp1, mr1, mw1, m2r1, rw1, imm1, alu1, bf1, il1, dn1} !== '0)
            $display("FAIL reset_outputs got=%h want=0",
                     {r1, cv1, br1, jp1, mr1, mw1, m2r1, rw1, imm1, alu1, bf1, il1, dn1});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({r1, cv1, il1, dn1, alu1} !== 8'b1000_0000)
            $display("FAIL reset_release got=%b want=10000000", {r1, cv1, il1, dn1, alu1});
        else pass_cnt++;
        en1 = 1'b0;
        #1;
        tot_cnt++;
        if (r1 !== 1'b0) $display("FAIL ready_when_stalled got=%b want=0", r1);
        else pass_cnt++;
        en1 = 1'b1;
    endtask

    task automatic test_add_latency();
        issue(1, 32'h002081B3, ev(1'b0, F_RW, 5'b00010, 3'b000));
        @(negedge clk);
        tot_cnt++;
        if ({cv1, r1, dn1} !== 3'b000) $display("FAIL add_decode_cycle got=%b want=000", {cv1, r1, dn1});
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({cv1, dn1, rw1, imm1, alu1} !== 8'b1110_0010)
            $display("FAIL add_exec_cycle got=%b want=11100010", {cv1, dn1, rw1, imm1, alu1});
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({r1, cv1, dn1} !== 3'b100) $display("FAIL add_back_idle got=%b want=100", {r1, cv1, dn1});
        else pass_cnt++;
    endtask

    task automatic test_decode();
        logic [31:0] tins[] = '{
            32'h0000A103, 32'h0020A023, 32'h00209463, 32'h0020F063, 32'h402081B3,
            32'h40315093, 32'h123452B7, 32'h00000097, 32'h008000EF, 32'h00008067,
            32'h0000000F, 32'h00000073, 32'h022081B3, 32'h00001067, 32'h0000B103,
            32'h0020A063, 32'h002081B2, 32'h40311093, 32'h0020C1B3, 32'h0FF0E093,
            32'h0020B023};
        exp_t texp[] = '{
            ev(1'b0, F_MR | F_M2R | F_RW | F_IMM, 5'b00010, 3'b000),
            ev(1'b0, F_MW | F_IMM, 5'b00010, 3'b000),
            ev(1'b0, F_BR, 5'b00110, 3'b001),
            ev(1'b0, F_BR, 5'b00100, 3'b111),
            ev(1'b0, F_RW, 5'b00110, 3'b000),
            ev(1'b0, F_RW | F_IMM, 5'b00111, 3'b000),
            ev(1'b0, F_RW | F_IMM, 5'b01010, 3'b000),
            ev(1'b0, F_RW | F_IMM, 5'b00010, 3'b000),
            ev(1'b0, F_JMP | F_RW | F_IMM, 5'b00010, 3'b000),
            ev(1'b0, F_JMP | F_RW | F_IMM, 5'b00010, 3'b000),
            ev(1'b0, 7'b0, 5'b00000, 3'b000),
            ev(1'b0, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000),
            ev(1'b0, F_RW, 5'b00001, 3'b000),
            ev(1'b0, F_RW | F_IMM, 5'b01000, 3'b000),
            ev(1'b1, 7'b0, 5'b00000, 3'b000)};
        for (int i = 0; i < tins.size(); i++) issue(1, tins[i], texp[i]);
    endtask

    task automatic test_back_to_back();
        int c0;
        issue(1, 32'h002081B3, ev(1'b0, F_RW, 5'b00010, 3'b000));
        c0 = acc_cyc;
        v1 = 1'b1;
        issue(1, 32'h402081B3, ev(1'b0, F_RW, 5'b00110, 3'b000));
        tot_cnt++;
        if (acc_cyc - c0 !== 3) $display("FAIL throughput got=%0d want=3", acc_cyc - c0);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int   nil = 0;
        int   nv  = 0;
        logic il_at2 = 1'b0;
        issue(1, 32'h00000000, ev(1'b1, 7'b0, 5'b00000, 3'b000));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            nil += int'(il1);
            nv  += int'(cv1 | dn1);
            if (k == 2) il_at2 = il1;
        end
        tot_cnt++;
        if (!(il_at2 === 1'b1 && nil == 1 && nv == 0))
            $display("FAIL illegal_pulse got il_at2=%b pulses=%0d valid_cycles=%0d want 1/1/0",
                     il_at2, nil, nv);
        else pass_cnt++;
    endtask

    task automatic test_m_ext();
        issue(2, 32'h022081B3, ev(1'b0, F_RW, 5'b10000, 3'b000));
        issue(2, 32'h0220D1B3, ev(1'b0, F_RW, 5'b10101, 3'b000));
        issue(2, 32'h042081B3, ev(1'b1, 7'b0, 5'b00000, 3'b000));
    endtask

    task automatic test_stall();
        issue(2, 32'h002081B3, ev(1'b0, F_RW, 5'b00010, 3'b000));
        for (int k = 1; k <= 8; k++) begin
            logic [3:0] want;  // {ctrl_valid, done, ins_ready, RegWrite}
            @(negedge clk);
            case (k)
                1:       want = 4'b0000;
                2, 3:    want = 4'b1001;
                4, 5:    want = 4'b1001;
                6, 7:    want = 4'b1101;
                default: want = 4'b0010;
            endcase
            tot_cnt++;
            if ({cv2, dn2, r2, rw2} !== want)
                $display("FAIL stall_cycle%0d got=%b want=%b", k, {cv2, dn2, r2, rw2}, want);
            else pass_cnt++;
            if (k == 3 || k == 6) en2 = 1'b0;
            if (k == 5 || k == 7) en2 = 1'b1;
        end
        tot_cnt++;
        if (alu2 !== 5'b00000) $display("FAIL stall_alu_after got=%b want=00000", alu2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec();
        issue(2, 32'h0000A103, ev(1'b0, F_MR | F_M2R | F_RW | F_IMM, 5'b00010, 3'b000));
        @(negedge clk);
        @(negedge clk);
        tot_cnt++;
        if ({cv2, mr2} !== 2'b11) $display("FAIL rst_precond got=%b want=11", {cv2, mr2});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({r2, cv2, mr2, m2r2, rw2, imm2, alu2, il2, dn2} !== '0)
            $display("FAIL rst_async got=%b want=0", {r2, cv2, mr2, m2r2, rw2, imm2, alu2, il2, dn2});
        else pass_cnt++;
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({r2, cv2, dn2} !== 3'b100) $display("FAIL rst_recover got=%b want=100", {r2, cv2, dn2});
        else pass_cnt++;
    endtask

    task automatic test_drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        tot_cnt++;
        if (q1.size() != 0 || q2.size() != 0)
            $display("FAIL drain pending1=%0d pending2=%0d want 0/0", q1.size(), q2.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_decode();
        test_back_to_back();
        test_illegal();
        test_m_ext();
        test_stall();
        test_drain();
        test_reset_mid_exec();
        test_drain();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
